// File: rtl/spectrum_pkg.sv
// Shared constants, state encoding and Hann coefficient generator for the
// spectrum front end.
package spectrum_pkg;

    localparam int unsigned FRAME_ADDR_BITS   = 10;
    localparam int unsigned SAMPLE_BITS       = 16;
    localparam int unsigned WIN_COEF_BITS     = 16;
    localparam int unsigned LOADER_FIFO_DEPTH = 4;

    // pi in Q30, used by the elaboration-time sine evaluation
    localparam longint HANN_PI_Q30 = 64'sd3373259426;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } loader_state_t;

    // Hann coefficient round((2**coef_bits-1) * sin^2(pi*k/N)), evaluated in
    // Q30 fixed point so it folds to a constant during elaboration. The index
    // is mirrored around N/2 first, so the table is exactly symmetric. The
    // small bias before the final shift makes exact half-LSB ties round up.
    function automatic longint hann_coef(input longint k, input int unsigned addr_bits,
                                         input int unsigned coef_bits);
        longint n;
        longint m;
        longint a;
        longint term;
        longint s;
        longint s2;
        longint maxc;
        longint c;
        n    = longint'(1) << addr_bits;
        m    = (k <= n / 2) ? k : n - k;
        a    = (HANN_PI_Q30 * m) / n;
        term = a;
        s    = a;
        for (int i = 1; i <= 10; i++) begin
            term = (term * a) >>> 30;
            term = (term * a) >>> 30;
            term = -term / longint'((2 * i) * (2 * i + 1));
            s    = s + term;
        end
        s2   = (s * s) >>> 30;
        maxc = (longint'(1) << coef_bits) - 1;
        c    = (maxc * s2 + (longint'(1) << 29) + 64'sd4096) >>> 30;
        if (c > maxc) c = maxc;
        if (c < 0)    c = 0;
        return c;
    endfunction

endpackage

// File: rtl/fft_frame_loader_hann_rom.sv
// Synchronous Hann window coefficient ROM; coefficient appears one clock
// after the address.
module hann_rom
    import spectrum_pkg::*;
#(
    parameter int unsigned ADDR_BITS = FRAME_ADDR_BITS,
    parameter int unsigned COEF_BITS = WIN_COEF_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] addr_i,
    output logic [COEF_BITS-1:0] coef_o
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [COEF_BITS-1:0] rom_c [DEPTH];
    logic [COEF_BITS-1:0] coef_d;
    logic [COEF_BITS-1:0] coef_q;

    // Constant table, folded at elaboration
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam logic [COEF_BITS-1:0] COEF =
            COEF_BITS'(hann_coef(longint'(gi), ADDR_BITS, COEF_BITS));
        assign rom_c[gi] = COEF;
    end

    // Table lookup
    always_comb begin
        coef_d = rom_c[addr_i];
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_q <= '0;
        end else begin
            coef_q <= coef_d;
        end
    end

    assign coef_o = coef_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Reads a completed frame from the codec double buffer, optionally applies a
// Hann window, and streams it to the FFT over valid/ready with last marking.
module fft_frame_loader
    import spectrum_pkg::*;
#(
    parameter int unsigned DATA_BITS  = SAMPLE_BITS,
    parameter int unsigned ADDR_BITS  = FRAME_ADDR_BITS,
    parameter int unsigned COEF_BITS  = WIN_COEF_BITS,
    parameter int unsigned FIFO_DEPTH = LOADER_FIFO_DEPTH
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 buffer_start_i,
    output logic [ADDR_BITS-1:0] buffer_raddr_o,
    input  logic [DATA_BITS-1:0] buffer_rdata_i,
    input  logic                 window_en_i,
    output logic [DATA_BITS-1:0] sample_o,
    output logic                 sample_valid_o,
    input  logic                 sample_ready_i,
    output logic                 sample_last_o,
    output logic                 frame_busy_o,
    output logic                 overrun_o
);

    localparam int unsigned PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS   = PTR_BITS + 1;
    localparam int unsigned PROD_BITS  = DATA_BITS + COEF_BITS + 1;
    localparam int unsigned ENTRY_BITS = DATA_BITS + 1;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
    localparam logic [CNT_BITS-1:0]  DEPTH_C   = CNT_BITS'(FIFO_DEPTH);

    loader_state_t state_q, state_d;

    logic                  start_prev_q, start_prev_d;
    logic                  win_q, win_d;
    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_BITS-1:0]  raddr_q, raddr_d;
    logic                  s0_q, s0_d;
    logic                  s0_last_q, s0_last_d;
    logic                  s1_q, s1_d;
    logic                  s1_last_q, s1_last_d;
    logic [ENTRY_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [ENTRY_BITS-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;

    logic                  start_edge_c;
    logic                  pop_c;
    logic                  push_c;
    logic                  head_last_c;
    logic [CNT_BITS-1:0]   inflight_c;
    logic [COEF_BITS-1:0]  rom_coef;
    logic signed [PROD_BITS-1:0] rdata_ext_c;
    logic signed [PROD_BITS-1:0] coef_ext_c;
    logic signed [PROD_BITS-1:0] prod_c;
    logic [DATA_BITS-1:0]  sample_c;

    // Window coefficient tracks the buffer read address with the same latency
    hann_rom #(
        .ADDR_BITS (ADDR_BITS),
        .COEF_BITS (COEF_BITS)
    ) u_hann_rom (
        .clk    (mclk),
        .rst_n  (rst_n),
        .addr_i (raddr_q),
        .coef_o (rom_coef)
    );

    // Next state, read issue, window datapath and FIFO bookkeeping
    always_comb begin
        state_d      = state_q;
        start_prev_d = buffer_start_i;
        win_d        = win_q;
        rd_addr_d    = rd_addr_q;
        raddr_d      = raddr_q;
        s0_d         = 1'b0;
        s0_last_d    = 1'b0;
        s1_d         = s0_q;
        s1_last_d    = s0_last_q;
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        busy_d       = busy_q;
        overrun_d    = 1'b0;

        start_edge_c = buffer_start_i & ~start_prev_q;
        pop_c        = valid_q & sample_ready_i;
        push_c       = s1_q;
        head_last_c  = fifo_mem_q[rd_ptr_q][DATA_BITS];
        inflight_c   = CNT_BITS'(s0_q) + CNT_BITS'(s1_q);

        // Product is exact in PROD_BITS; the floor shift cannot overflow
        rdata_ext_c  = PROD_BITS'($signed(buffer_rdata_i));
        coef_ext_c   = PROD_BITS'({1'b0, rom_coef});
        prod_c       = rdata_ext_c * coef_ext_c;
        sample_c     = win_q ? DATA_BITS'(prod_c >>> COEF_BITS) : buffer_rdata_i;

        case (state_q)
            IDLE: begin
                if (start_edge_c) begin
                    state_d   = RUN;
                    rd_addr_d = '0;
                    win_d     = window_en_i;
                    busy_d    = 1'b1;
                end
            end
            RUN: begin
                overrun_d = start_edge_c;
                // Reserve a FIFO slot for every read before it is issued
                if ((count_q + inflight_c) < DEPTH_C) begin
                    raddr_d   = rd_addr_q;
                    s0_d      = 1'b1;
                    s0_last_d = (rd_addr_q == LAST_ADDR);
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_BITS'(1);
                    end
                end
            end
            DRAIN: begin
                overrun_d = start_edge_c;
                if (pop_c && head_last_c && !s0_q && !s1_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (push_c) begin
            fifo_mem_d[wr_ptr_q] = {s1_last_q, sample_c};
            wr_ptr_d             = wr_ptr_q + PTR_BITS'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end
        count_d = count_q + CNT_BITS'(push_c) - CNT_BITS'(pop_c);
        valid_d = (count_d != '0);
    end

    // FSM state register
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, pipeline and FIFO registers; reset flushes everything
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev_q <= 1'b0;
            win_q        <= 1'b0;
            rd_addr_q    <= '0;
            raddr_q      <= '0;
            s0_q         <= 1'b0;
            s0_last_q    <= 1'b0;
            s1_q         <= 1'b0;
            s1_last_q    <= 1'b0;
            fifo_mem_q   <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            start_prev_q <= start_prev_d;
            win_q        <= win_d;
            rd_addr_q    <= rd_addr_d;
            raddr_q      <= raddr_d;
            s0_q         <= s0_d;
            s0_last_q    <= s0_last_d;
            s1_q         <= s1_d;
            s1_last_q    <= s1_last_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign buffer_raddr_o = raddr_q;
    assign sample_o       = fifo_mem_q[rd_ptr_q][DATA_BITS-1:0];
    assign sample_last_o  = fifo_mem_q[rd_ptr_q][DATA_BITS];
    assign sample_valid_o = valid_q;
    assign frame_busy_o   = busy_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: ramp and constant frames, window on and
// off, random backpressure, start-edge overrun and mid-frame reset.
module tb_fft_frame_loader;

    localparam int N = 1024;

    logic        mclk;
    logic        rst_n;
    logic        buffer_start_i;
    logic [9:0]  buffer_raddr_o;
    logic [15:0] buffer_rdata_i;
    logic        window_en_i;
    logic [15:0] sample_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic        sample_last_o;
    logic        frame_busy_o;
    logic        overrun_o;

    logic [15:0] buf_mem  [N];
    logic [15:0] got_data [N];

    int n_vec;
    int n_err;
    int n_got;
    int n_last;
    int last_idx;
    int n_ovr;
    int n_stall;
    int lat;
    bit aborted;

    fft_frame_loader dut (
        .mclk           (mclk),
        .rst_n          (rst_n),
        .buffer_start_i (buffer_start_i),
        .buffer_raddr_o (buffer_raddr_o),
        .buffer_rdata_i (buffer_rdata_i),
        .window_en_i    (window_en_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_last_o  (sample_last_o),
        .frame_busy_o   (frame_busy_o),
        .overrun_o      (overrun_o)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Codec buffer: read data one clock after the address
    always @(posedge mclk) buffer_rdata_i <= buf_mem[buffer_raddr_o];

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ideal Hann-windowed value of v at index k (floor of v*coef/2**16)
    function automatic longint win_expect(input longint v, input int k);
        real    c;
        longint ci;
        c  = 65535.0 * 0.5 * (1.0 - $cos(2.0 * 3.141592653589793 * real'(k) / 1024.0));
        ci = longint'($floor(c + 0.5));
        return (v * ci) >>> 16;
    endfunction

    task automatic fill_ramp();
        for (int k = 0; k < N; k++) buf_mem[k] = 16'(k);
    endtask

    task automatic fill_const(input logic [15:0] v);
        for (int k = 0; k < N; k++) buf_mem[k] = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_raddr"},   buffer_raddr_o, 0);
        check({tag, "_sample"},  sample_o, 0);
        check({tag, "_valid"},   sample_valid_o, 0);
        check({tag, "_last"},    sample_last_o, 0);
        check({tag, "_busy"},    frame_busy_o, 0);
        check({tag, "_overrun"}, overrun_o, 0);
    endtask

    // Pulse start, collect transfers; optional second edge, window toggle or reset
    task automatic run_frame(input bit rnd, input int hold, input int edge_at,
                             input int rst_at, input int win_off_at);
        int          cyc;
        int          edge_cyc;
        bit          pv;
        logic [15:0] pd;
        logic        pl;
        logic        rdy;
        n_got = 0; n_last = 0; last_idx = -1; n_ovr = 0; n_stall = 0; lat = -1;
        aborted = 1'b0; cyc = 0; edge_cyc = -1; pv = 1'b0; pd = '0; pl = 1'b0;
        @(negedge mclk);
        buffer_start_i = 1'b1;
        while (n_got < N && cyc < 20000) begin
            @(negedge mclk);
            cyc++;
            if (cyc == hold) buffer_start_i = 1'b0;
            if (cyc == win_off_at) window_en_i = 1'b0;
            if (n_got == edge_at && edge_cyc < 0) begin
                buffer_start_i = 1'b1;
                edge_cyc = cyc;
            end
            if (edge_cyc >= 0 && cyc == edge_cyc + 2) buffer_start_i = 1'b0;
            if (n_got == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                aborted = 1'b1;
                break;
            end
            if (overrun_o) n_ovr++;
            if (lat < 0 && sample_valid_o) begin
                lat = cyc - 1;
                check("busy_in_frame", frame_busy_o, 1);
            end
            if (pv && (!sample_valid_o || sample_o != pd || sample_last_o != pl)) n_stall++;
            rdy = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            sample_ready_i = rdy;
            if (sample_valid_o && rdy) begin
                got_data[n_got] = sample_o;
                if (sample_last_o) begin
                    n_last++;
                    last_idx = n_got;
                end
                n_got++;
            end
            pv = sample_valid_o && !rdy;
            pd = sample_o;
            pl = sample_last_o;
        end
        if (!aborted) begin
            check("frame_count", n_got, N);
            @(negedge mclk);
            check("busy_after_last", frame_busy_o, 0);
            check("valid_after_last", sample_valid_o, 0);
            check("raddr_held", buffer_raddr_o, N - 1);
            sample_ready_i = 1'b1;
        end
        buffer_start_i = 1'b0;
    endtask

    task automatic check_ramp(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < N; k++) if (got_data[k] != 16'(k)) bad++;
        check({tag, "_ramp_bad"}, bad, 0);
        check({tag, "_n_last"}, n_last, 1);
        check({tag, "_last_idx"}, last_idx, N - 1);
    endtask

    task automatic check_window(input string tag, input longint v);
        int     bad;
        int     sym_bad;
        longint d;
        bad = 0;
        sym_bad = 0;
        for (int k = 0; k < N; k++) begin
            d = longint'($signed(got_data[k])) - win_expect(v, k);
            if (d > 1 || d < -1) bad++;
        end
        for (int k = 1; k < N / 2; k++) if (got_data[k] != got_data[N - k]) sym_bad++;
        check({tag, "_model_bad"}, bad, 0);
        check({tag, "_sym_bad"}, sym_bad, 0);
        check({tag, "_out0"}, got_data[0], 0);
        check({tag, "_last_idx"}, last_idx, N - 1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        buffer_start_i = 1'b0;
        window_en_i = 1'b0;
        sample_ready_i = 1'b1;
        fill_ramp();
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        repeat (2) @(negedge mclk);

        // Ramp, window off, ready always high
        run_frame(1'b0, 1, -1, -1, -1);
        check("t1_latency", lat, 3);
        check("t1_overrun", n_ovr, 0);
        check_ramp("t1");

        // Constant 0x7FFF windowed; window_en dropped mid-frame must not matter
        fill_const(16'h7FFF);
        window_en_i = 1'b1;
        run_frame(1'b0, 1, -1, -1, 10);
        check("t2_out512", got_data[512], 16'h7FFE);
        check_window("t2", 32767);

        // Constant 0x8000 windowed: exact floor at the peak
        fill_const(16'h8000);
        window_en_i = 1'b1;
        run_frame(1'b0, 1, -1, -1, -1);
        check("t3_out512", got_data[512], 16'h8000);
        check_window("t3", -32768);

        // Ramp with random backpressure
        fill_ramp();
        window_en_i = 1'b0;
        run_frame(1'b1, 1, -1, -1, -1);
        check("t4_latency", lat, 3);
        check("t4_stall_unstable", n_stall, 0);
        check_ramp("t4");

        // Start held 5 cycles, second edge near sample 300
        run_frame(1'b0, 5, 300, -1, -1);
        check("t5_overrun", n_ovr, 1);
        check_ramp("t5");

        // Reset mid-frame, then a clean frame
        run_frame(1'b0, 1, -1, 500, -1);
        check("t6_aborted", aborted, 1);
        repeat (2) @(negedge mclk);
        check_reset_outputs("t6_held");
        rst_n = 1'b1;
        repeat (2) @(negedge mclk);
        run_frame(1'b0, 1, -1, -1, -1);
        check("t6_latency", lat, 3);
        check("t6_overrun", n_ovr, 0);
        check_ramp("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
